reg_scoreboard: RTL and testbench

Issue-stage register scoreboard for the pipelined MIPS processor. It tracks in-flight writes to each of the 32 architectural registers and stalls decode while any source operand, or a saturated destination, has a write still pending. It sits between the decode/issue stage and the register file write-back port. Register 0 is never tracked.

---
 rtl/sb_pkg.sv | 15 +
 rtl/sb_entry.sv | 42 ++++
 rtl/reg_scoreboard.sv | 118 +++++++++++
 tb/tb_reg_scoreboard.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types and sizing constants for the issue-stage register scoreboard.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sb_pkg;

  localparam int REG_CNT     = 32;
  localparam int REG_AW      = 5;
  localparam int MAX_PER_REG = 3;  // outstanding writes allowed to one register
  localparam int MAX_TOTAL   = 8;  // outstanding writes allowed across all registers

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [1:0]        sb_cnt_t;
  typedef logic [6:0]        sb_cnt_total_t;

endpackage

// File: rtl/sb_entry.sv
// Per-register pending-write counter for the scoreboard.
// Latency: count/busy update one cycle after inc/dec; underflow is combinational.
// Backpressure: none; the caller never increments a saturated counter.
// Ports: clk, rst_n (sync, active low), inc/dec requests, count, busy (count != 0),
//        underflow (decrement requested on an empty counter).
module sb_entry
  import sb_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    inc,
  input  logic    dec,
  output sb_cnt_t count,
  output logic    busy,
  output logic    underflow
);

  sb_cnt_t cnt_q;
  sb_cnt_t cnt_d;

  // Simultaneous inc and dec cancel, so the counter holds and no underflow is
  // raised: the write-back is matched against the instruction issuing now.
  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (cnt_q != sb_cnt_t'(MAX_PER_REG)) cnt_d = cnt_q + 2'd1;
    end else if (dec && !inc) begin
      if (cnt_q == '0) underflow = 1'b1;
      else             cnt_d     = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign busy  = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-stage register scoreboard: tracks in-flight writes per register, stalls decode on hazards.
// Latency: stall is combinational; busy_mask/inflight/err_underflow update one cycle after the edge.
// Backpressure: stall holds the decode instruction while a source is pending or the dest/total is full.
// Ports: clk, rst_n (sync, active low); issue_* from decode, stall back to decode;
//        wb_valid/wb_dest from write-back; busy_mask, inflight, err_underflow (sticky) status.
// Build option: define SB_WB_BYPASS_EN to let a same-cycle write-back release the hazard it retires.
module reg_scoreboard
  import sb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  reg_idx_t      issue_src1,
  input  reg_idx_t      issue_src2,
  input  logic          issue_use_src2,
  input  logic          issue_has_dest,
  input  reg_idx_t      issue_dest,
  output logic          stall,
  input  logic          wb_valid,
  input  reg_idx_t      wb_dest,
  output logic [31:0]   busy_mask,
  output sb_cnt_total_t inflight,
  output logic          err_underflow
);

  sb_cnt_t              cnt [REG_CNT];
  logic [REG_CNT-1:1]   inc_vec;
  logic [REG_CNT-1:1]   dec_vec;
  logic [REG_CNT-1:1]   busy_vec;
  logic [REG_CNT-1:1]   uf_vec;

  sb_cnt_total_t inflight_q, inflight_d;
  logic          err_q, err_d;

  logic          wb_live;   // write-back to a tracked register
  logic          wb_hit;    // write-back that actually retires a pending write
  logic          accept;
  logic          do_inc;
  logic          do_dec;
  logic          src1_pend, src2_pend, dest_full;
  sb_cnt_t       dest_cnt_eff;
  sb_cnt_total_t inflight_eff;

  // Register 0 is hard-wired and never tracked.
  assign cnt[0] = '0;

  for (genvar r = 1; r < REG_CNT; r++) begin : g_entry
    sb_entry u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_vec[r]),
      .dec       (dec_vec[r]),
      .count     (cnt[r]),
      .busy      (busy_vec[r]),
      .underflow (uf_vec[r])
    );
  end

  assign wb_live = wb_valid && (wb_dest != '0);
  assign wb_hit  = wb_live && (cnt[wb_dest] != '0);

  always_comb begin
    src1_pend    = (issue_src1 != '0) && (cnt[issue_src1] != '0);
    src2_pend    = (issue_src2 != '0) && (cnt[issue_src2] != '0);
    dest_cnt_eff = cnt[issue_dest];
    inflight_eff = inflight_q;
`ifdef SB_WB_BYPASS_EN
    // The register file writes on negedge, so a read launched at the next
    // posedge already sees this write-back's data: the last pending write can
    // be treated as retired now.
    if (wb_live && (wb_dest == issue_src1) && (cnt[issue_src1] == 2'd1)) src1_pend = 1'b0;
    if (wb_live && (wb_dest == issue_src2) && (cnt[issue_src2] == 2'd1)) src2_pend = 1'b0;
    if (wb_hit && (wb_dest == issue_dest)) dest_cnt_eff = cnt[issue_dest] - 2'd1;
    if (wb_hit) inflight_eff = inflight_q - 7'd1;
`endif
    dest_full = issue_has_dest && (issue_dest != '0) &&
                ((dest_cnt_eff == sb_cnt_t'(MAX_PER_REG)) ||
                 (inflight_eff == sb_cnt_total_t'(MAX_TOTAL)));
    stall = issue_valid && (src1_pend || (issue_use_src2 && src2_pend) || dest_full);
  end

  assign accept = issue_valid && !stall;
  assign do_inc = accept && issue_has_dest && (issue_dest != '0);
  // A write-back to an empty register still cancels a same-cycle issue to it.
  assign do_dec = wb_hit || (wb_live && do_inc && (issue_dest == wb_dest));

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < REG_CNT; r++) begin
      inc_vec[r] = do_inc  && (issue_dest == reg_idx_t'(r));
      dec_vec[r] = wb_live && (wb_dest    == reg_idx_t'(r));
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (do_inc && !do_dec)      inflight_d = inflight_q + 7'd1;
    else if (do_dec && !do_inc) inflight_d = inflight_q - 7'd1;
    err_d = err_q | (|uf_vec);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Counters are flops, so the busy mask already changes only at the clock edge.
  assign busy_mask     = {busy_vec, 1'b0};
  assign inflight      = inflight_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
// Latency: inputs driven 1 time unit after posedge, outputs sampled before the next edge.
// Backpressure: stall is checked combinationally against hand-computed expectations.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_src1;
  logic [4:0]  issue_src2;
  logic        issue_use_src2;
  logic        issue_has_dest;
  logic [4:0]  issue_dest;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] busy_mask;
  logic [6:0]  inflight;
  logic        err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  reg_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_src1     (issue_src1),
    .issue_src2     (issue_src2),
    .issue_use_src2 (issue_use_src2),
    .issue_has_dest (issue_has_dest),
    .issue_dest     (issue_dest),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_dest        (wb_dest),
    .busy_mask      (busy_mask),
    .inflight       (inflight),
    .err_underflow  (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid    = 1'b0;
    issue_src1     = '0;
    issue_src2     = '0;
    issue_use_src2 = 1'b0;
    issue_has_dest = 1'b0;
    issue_dest     = '0;
    wb_valid       = 1'b0;
    wb_dest        = '0;
  endtask

  task automatic drive_issue(input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                             input logic hd, input logic [4:0] d);
    issue_valid    = 1'b1;
    issue_src1     = s1;
    issue_src2     = s2;
    issue_use_src2 = u2;
    issue_has_dest = hd;
    issue_dest     = d;
  endtask

  task automatic drive_wb(input logic [4:0] d);
    wb_valid = 1'b1;
    wb_dest  = d;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    drive_issue(5'd3, 5'd4, 1'b1, 1'b1, 5'd6);
    drive_wb(5'd4);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    n_checks++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 00000000", busy_mask); end
    n_checks++; if (inflight !== 7'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_underflow); end
    drive_issue(5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_first_issue_stall: got %b want 0", stall); end
    tick();
    idle();
  endtask

  task automatic test_raw();
    do_reset();
    drive_issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd5);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_dest_issue_stall: got %b want 0", stall); end
    tick();
    idle();
    #1;
    n_checks++; if (busy_mask !== 32'h0000_0020) begin n_fail++; $display("FAIL raw_busy5: got %h want 00000020", busy_mask); end
    n_checks++; if (inflight !== 7'd1) begin n_fail++; $display("FAIL raw_inflight1: got %0d want 1", inflight); end
    drive_issue(5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_src1_stall: got %b want 1", stall); end
    tick();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_src1_stall_hold: got %b want 1", stall); end
    drive_wb(5'd5);
    #1;
    n_checks++; if (stall !== !BYP) begin n_fail++; $display("FAIL raw_wb_same_cycle_stall: got %b want %b", stall, !BYP); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_after_wb_stall: got %b want 0", stall); end
    n_checks++; if (inflight !== 7'd0) begin n_fail++; $display("FAIL raw_after_wb_inflight: got %0d want 0", inflight); end
    tick();
    idle();
  endtask

  task automatic test_src2();
    do_reset();
    drive_issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd6);
    tick();
    drive_issue(5'd0, 5'd6, 1'b0, 1'b0, 5'd0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL src2_unused_stall: got %b want 0", stall); end
    issue_use_src2 = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL src2_used_stall: got %b want 1", stall); end
    idle();
  endtask

  task automatic test_waw();
    do_reset();
    drive_issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd7);
    tick();
    tick();
    tick();
    idle();
    #1;
    n_checks++; if (inflight !== 7'd3) begin n_fail++; $display("FAIL waw_inflight3: got %0d want 3", inflight); end
    drive_issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd7);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_fourth_stall: got %b want 1", stall); end
    drive_wb(5'd7);
    #1;
    n_checks++; if (stall !== !BYP) begin n_fail++; $display("FAIL waw_wb_same_cycle_stall: got %b want %b", stall, !BYP); end
    tick();
    wb_valid = 1'b0;
    // Without bypass the fourth issue goes through on the cycle after the write-back.
    if (!BYP) tick();
    idle();
    #1;
    n_checks++; if (inflight !== 7'd3) begin n_fail++; $display("FAIL waw_fourth_accepted_inflight: got %0d want 3", inflight); end
    n_checks++; if (busy_mask !== 32'h0000_0080) begin n_fail++; $display("FAIL waw_busy7: got %h want 00000080", busy_mask); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive_issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd9);
    tick();
    drive_wb(5'd9);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL same_cycle_stall: got %b want 0", stall); end
    tick();
    idle();
    #1;
    n_checks++; if (inflight !== 7'd1) begin n_fail++; $display("FAIL same_cycle_inflight: got %0d want 1", inflight); end
    n_checks++; if (busy_mask !== 32'h0000_0200) begin n_fail++; $display("FAIL same_cycle_busy9: got %h want 00000200", busy_mask); end
  endtask

  task automatic test_underflow();
    do_reset();
    drive_wb(5'd12);
    #1;
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_not_yet: got %b want 0", err_underflow); end
    tick();
    idle();
    #1;
    n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b want 1", err_underflow); end
    n_checks++; if (inflight !== 7'd0) begin n_fail++; $display("FAIL uf_inflight: got %0d want 0", inflight); end
    tick();
    tick();
    n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
    drive_issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b want 0", stall); end
    tick();
    tick();
    idle();
    #1;
    n_checks++; if (inflight !== 7'd0) begin n_fail++; $display("FAIL r0_inflight: got %0d want 0", inflight); end
    n_checks++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL r0_busy: got %h want 00000000", busy_mask); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_cleared_by_reset: got %b want 0", err_underflow); end
  endtask

  task automatic test_capacity();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive_issue(5'd0, 5'd0, 1'b0, 1'b1, 5'(i));
      tick();
    end
    idle();
    #1;
    n_checks++; if (inflight !== 7'd8) begin n_fail++; $display("FAIL cap_inflight8: got %0d want 8", inflight); end
    n_checks++; if (busy_mask !== 32'h0000_01FE) begin n_fail++; $display("FAIL cap_busy: got %h want 000001fe", busy_mask); end
    drive_issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd20);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL cap_ninth_dest_stall: got %b want 1", stall); end
    drive_issue(5'd3, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL cap_src_busy_stall: got %b want 1", stall); end
    drive_issue(5'd20, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL cap_ninth_nodest_stall: got %b want 0", stall); end
    tick();
    idle();
    #1;
    n_checks++; if (inflight !== 7'd8) begin n_fail++; $display("FAIL cap_inflight_hold: got %0d want 8", inflight); end
    drive_issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd21);
    drive_wb(5'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    n_checks++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL cap_reset_busy: got %h want 00000000", busy_mask); end
    n_checks++; if (inflight !== 7'd0) begin n_fail++; $display("FAIL cap_reset_inflight: got %0d want 0", inflight); end
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    test_reset();
    test_raw();
    test_src2();
    test_waw();
    test_same_cycle();
    test_underflow();
    test_capacity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
